// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared binDCT types, fraction width and rounding helper
package dct_pkg;

   localparam int W_FRAC = 3;

   typedef logic [7:0][15:0] coef_vec_t;
   typedef logic signed [31:0] acc_t;

   // Round a 3-fractional-bit value to an integer, half away from zero; result keeps the fraction bits (zeroed)
   function automatic acc_t bin_round(input acc_t v);
      acc_t m;
      m = (v < 0) ? -v : v;
      m = ((m + acc_t'(1 <<< (W_FRAC - 1))) >>> W_FRAC) <<< W_FRAC;
      return (v < 0) ? -m : m;
   endfunction

endpackage

// File: rtl/dct_it_stage_ctrl.sv
// rtl/dct_it_stage_ctrl.sv - valid/last shift chain with whole-pipe stall
module dct_it_stage_ctrl #(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_last,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             advance,
   output logic [DEPTH-2:0] stage_valid,
   output logic             out_valid,
   output logic             out_last
);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] last;

   assign out_valid   = valid[DEPTH-1];
   assign out_last    = last[DEPTH-1];
   assign stage_valid = valid[DEPTH-2:0];
   assign advance     = ~(out_valid & ~out_ready);
   assign in_ready    = advance;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         last  <= '0;
      end else if (advance) begin
         valid <= {valid[DEPTH-2:0], in_valid};
         last  <= {last[DEPTH-2:0], in_valid & in_last};
      end
   end

endmodule

// File: rtl/dct_it_math.sv
// rtl/dct_it_math.sv - 8-point inverse binDCT lifting pipeline with saturated output
module dct_it_math
   import dct_pkg::*;
#(
   parameter int W_O   = 8,
   parameter int W_INT = 22
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  coef_vec_t             in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0][W_O-1:0]   out_data,
   output logic                  out_last,
   output logic [7:0]            out_sat
);

   localparam acc_t SMAX = acc_t'((1 <<< (W_O - 1)) - 1);
   localparam acc_t SMIN = -SMAX - 1;

   logic             advance;
   logic [6:0]       stage_valid;

   logic signed [W_INT-1:0] s0 [8], s1 [8], s2 [8], s3 [8], s4 [8], s5 [8], s6 [8];
   acc_t e0 [8], e1 [8], e2 [8], e3 [8], e4 [8], e5 [8], e6 [8];
   acc_t n1 [8], n2 [8], n3 [8], n4 [8], n5 [8], n6 [8];
   acc_t y [8];
   logic [7:0] clip;

   dct_it_stage_ctrl #(.DEPTH(8)) u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .out_ready   (out_ready),
      .in_ready    (in_ready),
      .advance     (advance),
      .stage_valid (stage_valid),
      .out_valid   (out_valid),
      .out_last    (out_last)
   );

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         e0[k] = acc_t'(s0[k]);
         e1[k] = acc_t'(s1[k]);
         e2[k] = acc_t'(s2[k]);
         e3[k] = acc_t'(s3[k]);
         e4[k] = acc_t'(s4[k]);
         e5[k] = acc_t'(s5[k]);
         e6[k] = acc_t'(s6[k]);
      end
   end

   // Slot map after S0: 0=c0 1=b7 2=d3 3=d6 4=d1 5=c5 6=c2 7=d4; S3 re-slots to a0..a7
   always_comb begin
      n1    = e0;
      n1[4] = bin_round(e0[0] >>> 1) - e0[4];
      n1[2] = e0[2] - bin_round((e0[6] >>> 3) + (e0[6] >>> 2));
      n1[7] = e0[7] + bin_round(e0[1] >>> 3);
      n1[3] = e0[3] + bin_round(e0[5] >>> 1);

      n2    = e1;
      n2[0] = e1[0] - e1[4];
      n2[6] = e1[6] + bin_round((e1[2] >>> 3) + (e1[2] >>> 2));
      n2[5] = e1[5] - bin_round((e1[3] >>> 3) + (e1[3] >>> 2) + (e1[3] >>> 1));

      n3[0] = (e2[0] + e2[2]) >>> 1;
      n3[3] = (e2[0] - e2[2]) >>> 1;
      n3[1] = (e2[4] + e2[6]) >>> 1;
      n3[2] = (e2[4] - e2[6]) >>> 1;
      n3[4] = (e2[7] + e2[5]) >>> 1;
      n3[5] = (e2[7] - e2[5]) >>> 1;
      n3[7] = (e2[1] + e2[3]) >>> 1;
      n3[6] = (e2[1] - e2[3]) >>> 1;

      n4    = e3;
      n4[5] = bin_round((e3[6] >>> 3) + (e3[6] >>> 1)) - e3[5];

      n5    = e4;
      n5[6] = e4[6] - bin_round((e4[5] >>> 3) + (e4[5] >>> 2));

      for (int i = 0; i < 4; i++) begin
         n6[i]     = (e5[i] + e5[7-i]) >>> 1;
         n6[7 - i] = (e5[i] - e5[7-i]) >>> 1;
      end
   end

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         y[k]    = bin_round(e6[k]) >>> W_FRAC;
         clip[k] = 1'b0;
         if (y[k] > SMAX) begin
            y[k]    = SMAX;
            clip[k] = 1'b1;
         end else if (y[k] < SMIN) begin
            y[k]    = SMIN;
            clip[k] = 1'b1;
         end
      end
   end

   // Each stage only loads when a real vector moves into it, so bubbles leave stale data untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) begin
            s0[k]       <= '0;
            s1[k]       <= '0;
            s2[k]       <= '0;
            s3[k]       <= '0;
            s4[k]       <= '0;
            s5[k]       <= '0;
            s6[k]       <= '0;
            out_data[k] <= '0;
         end
         out_sat <= '0;
      end else if (advance) begin
         for (int k = 0; k < 8; k++) begin
            if (in_valid)       s0[k] <= W_INT'(acc_t'($signed(in_data[k])) <<< W_FRAC);
            if (stage_valid[0]) s1[k] <= W_INT'(n1[k]);
            if (stage_valid[1]) s2[k] <= W_INT'(n2[k]);
            if (stage_valid[2]) s3[k] <= W_INT'(n3[k]);
            if (stage_valid[3]) s4[k] <= W_INT'(n4[k]);
            if (stage_valid[4]) s5[k] <= W_INT'(n5[k]);
            if (stage_valid[5]) s6[k] <= W_INT'(n6[k]);
            if (stage_valid[6]) out_data[k] <= W_O'(y[k]);
         end
         if (stage_valid[6]) out_sat <= clip;
      end
   end

endmodule

// File: tb/tb_dct_it_math.sv
// tb/tb_dct_it_math.sv - self-checking bench for dct_it_math against a behavioural inverse binDCT model
module tb_dct_it_math;

   typedef struct packed {
      logic        l;
      logic [7:0]  s;
      logic [63:0] d;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [7:0][15:0]  in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [7:0][7:0]   out_data;
   logic              out_last;
   logic [7:0]        out_sat;

   int compared   = 0;
   int mismatched = 0;
   exp_t q[$];

   dct_it_math #(.W_O(8), .W_INT(22)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int r8(input int v);
      int m;
      m = (v < 0) ? -v : v;
      m = (m + 4) / 8 * 8;
      return (v < 0) ? -m : m;
   endfunction

   function automatic exp_t model(input int cx[8], input logic last);
      int c0, b7, d3, d6, d1, c5, c2, d4, b0, b1, b2, b3, b4, b5, b6, v;
      int a[8];
      int xs[8];
      exp_t e;
      c0 = cx[0] * 8; b7 = cx[1] * 8; d3 = cx[2] * 8; d6 = cx[3] * 8;
      d1 = cx[4] * 8; c5 = cx[5] * 8; c2 = cx[6] * 8; d4 = cx[7] * 8;
      b1 = r8(c0 >>> 1) - d1;
      b3 = d3 - r8((c2 >>> 3) + (c2 >>> 2));
      b4 = d4 + r8(b7 >>> 3);
      b6 = d6 + r8(c5 >>> 1);
      b0 = c0 - b1;
      b2 = c2 + r8((b3 >>> 3) + (b3 >>> 2));
      b5 = c5 - r8((b6 >>> 3) + (b6 >>> 2) + (b6 >>> 1));
      a[0] = (b0 + b3) >>> 1; a[3] = (b0 - b3) >>> 1;
      a[1] = (b1 + b2) >>> 1; a[2] = (b1 - b2) >>> 1;
      a[4] = (b4 + b5) >>> 1; a[5] = (b4 - b5) >>> 1;
      a[7] = (b7 + b6) >>> 1; a[6] = (b7 - b6) >>> 1;
      a[5] = r8((a[6] >>> 3) + (a[6] >>> 1)) - a[5];
      a[6] = a[6] - r8((a[5] >>> 3) + (a[5] >>> 2));
      for (int i = 0; i < 4; i++) begin
         xs[i]     = (a[i] + a[7-i]) >>> 1;
         xs[7 - i] = (a[i] - a[7-i]) >>> 1;
      end
      e.l = last;
      e.s = '0;
      e.d = '0;
      for (int n = 0; n < 8; n++) begin
         v = r8(xs[n]) / 8;
         if (v > 127) begin v = 127; e.s[n] = 1'b1; end
         else if (v < -128) begin v = -128; e.s[n] = 1'b1; end
         e.d[n*8 +: 8] = 8'(v);
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic rand_vec(output int cx[8]);
      bit full;
      full = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 8; k++)
         cx[k] = full ? int'($signed(16'($urandom))) : int'($urandom_range(0, 1023)) - 512;
   endtask

   task automatic drive_vec(input int cx[8], input logic last);
      for (int k = 0; k < 8; k++) in_data[k] = 16'(cx[k]);
      in_last  = last;
      in_valid = 1'b1;
   endtask

   task automatic send_one(input int cx[8], input logic last, input string tag);
      int lat;
      exp_t e;
      e = model(cx, last);
      out_ready = 1'b1;
      drive_vec(cx, last);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 128'(lat), 128'(8));
      chk({tag, " model"}, 128'({out_last, out_sat, out_data}), 128'(e));
   endtask

   initial begin
      int v[8];
      int cur[8];
      int sent, rcvd, cyc;
      logic cur_last, acc, stalled_prev, seen;
      logic [72:0] held;
      exp_t e;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", 128'(out_valid), 128'(0));
      chk("reset in_ready", 128'(in_ready), 128'(1));
      chk("reset outputs", 128'({out_last, out_sat, out_data}), 128'(0));
      @(negedge clk) rst_n = 1'b1;

      v = '{0, 0, 0, 0, 0, 0, 0, 0};
      send_one(v, 1'b1, "zero");
      chk("zero const", 128'({out_last, out_sat, out_data}), 128'({1'b1, 8'h00, 64'h0}));

      v = '{64, 0, 0, 0, 0, 0, 0, 0};
      send_one(v, 1'b0, "dc_pos");
      chk("dc_pos const", 128'({out_sat, out_data}), 128'({8'h00, {8{8'h08}}}));

      v = '{-64, 0, 0, 0, 0, 0, 0, 0};
      send_one(v, 1'b0, "dc_neg");
      chk("dc_neg const", 128'({out_sat, out_data}), 128'({8'h00, {8{8'hF8}}}));

      v = '{1600, 0, 0, 0, 0, 0, 0, 0};
      send_one(v, 1'b0, "sat_pos");
      chk("sat_pos const", 128'({out_sat, out_data}), 128'({8'hFF, {8{8'h7F}}}));

      v = '{-1600, 0, 0, 0, 0, 0, 0, 0};
      send_one(v, 1'b1, "sat_neg");
      chk("sat_neg const", 128'({out_last, out_sat, out_data}), 128'({1'b1, 8'hFF, {8{8'h80}}}));

      // random stream under random backpressure
      sent = 0; rcvd = 0; acc = 1'b0; stalled_prev = 1'b0; held = '0; cur_last = 1'b0;
      for (cyc = 0; cyc < 20000 && rcvd < 200; cyc++) begin
         @(posedge clk); #1;
         if (stalled_prev) begin
            chk("stall hold valid", 128'(out_valid), 128'(1));
            chk("stall hold data", 128'({out_last, out_sat, out_data}), 128'(held));
         end
         if (acc) in_valid = 1'b0;
         acc = 1'b0;
         out_ready = ($urandom_range(0, 2) != 0);
         if (!in_valid && sent < 200 && $urandom_range(0, 4) != 0) begin
            rand_vec(cur);
            cur_last = 1'($urandom_range(0, 1));
            drive_vec(cur, cur_last);
         end
         #1;
         stalled_prev = out_valid && !out_ready;
         held = {out_last, out_sat, out_data};
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("stream spurious output", 128'(1), 128'(0));
            end else begin
               e = q.pop_front();
               chk("stream output", 128'({out_last, out_sat, out_data}), 128'(e));
            end
            rcvd++;
         end
         if (in_valid && in_ready) begin
            q.push_back(model(cur, cur_last));
            sent++;
            acc = 1'b1;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("stream received", 128'(rcvd), 128'(200));
      chk("stream leftover", 128'(q.size()), 128'(0));

      // reset with vectors in flight
      out_ready = 1'b1;
      for (int n = 0; n < 9; n++) begin
         rand_vec(cur);
         drive_vec(cur, 1'b1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("pre-reset out_valid", 128'(out_valid), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("mid reset out_valid", 128'(out_valid), 128'(0));
      chk("mid reset outputs", 128'({out_last, out_sat, out_data}), 128'(0));
      chk("mid reset in_ready", 128'(in_ready), 128'(1));
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("no stale out_valid", 128'(seen), 128'(0));
      rand_vec(v);
      send_one(v, 1'b1, "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
